// File: rtl/dsc_mul_ms_param.sv
// Deterministic stochastic-computing multiplier.
// Operand A is a fast unary ramp stream and operand B a clock-divided ramp
// stream. LANES bits of both streams are ANDed per cycle, and their popcount
// is accumulated into the exact product a*b.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; operands and es_en are latched on accept
// S_RUN  | streaming chunks; en=0 stalls counters and accumulator
// S_DONE | one-cycle done pulse; z already holds the result
module dsc_mul_ms_param #(
    parameter int WIDTH = 4,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               en,
    input  logic               es_en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    localparam int P  = 1 << WIDTH;
    localparam int AW = 2 * WIDTH;
    localparam logic [WIDTH:0]   LANES_W = (WIDTH + 1)'(LANES);
    localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(P - 1);

    // LANES must evenly divide the stream period, or the ramp chunks
    // would straddle a period boundary.
    if (LANES < 1 || LANES > P || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $fatal(1, "dsc_mul_ms_param: LANES must be a power of 2 in [1, 2**WIDTH]");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] ctr_a, ctr_b;
    logic             es_reg;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_nxt;
    logic [AW-1:0]    chunk_pop;
    logic [WIDTH:0]   ctr_a_sum;
    logic             wrap_a;
    logic             last_chunk;
    logic             skip_run;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // With ES on, a zero operand means the product is zero, so skip streaming.
    assign skip_run = es_en && ((a == '0) || (b == '0));

    // ctr_a is advanced with one extra bit so that the carry marks the end of
    // an A period even when LANES == P.
    always_comb begin
        ctr_a_sum = {1'b0, ctr_a} + LANES_W;
        wrap_a    = ctr_a_sum[WIDTH];
    end

    // Popcount of lane-wise (A-bit AND B-bit) for the current chunk.
    always_comb begin
        chunk_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            if ((({1'b0, ctr_a} + (WIDTH + 1)'(k)) < {1'b0, a_reg}) && (ctr_b < b_reg)) begin
                chunk_pop = chunk_pop + AW'(1);
            end
        end
        acc_nxt = acc + chunk_pop;
    end

    // Terminal chunk: last A chunk of the last B step that can still add ones.
    always_comb begin
        if (es_reg) begin
            last_chunk = wrap_a && (({1'b0, ctr_b} + (WIDTH + 1)'(1)) == {1'b0, b_reg});
        end else begin
            last_chunk = wrap_a && (ctr_b == CTR_MAX);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = skip_run ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (en && last_chunk) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, ramp counters, accumulator and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            es_reg <= 1'b0;
            ctr_a  <= '0;
            ctr_b  <= '0;
            acc    <= '0;
            z      <= '0;
        end else if (state == S_IDLE && start) begin
            a_reg  <= a;
            b_reg  <= b;
            es_reg <= es_en;
            ctr_a  <= '0;
            ctr_b  <= '0;
            acc    <= '0;
            z      <= '0;
        end else if (state == S_RUN && en) begin
            acc   <= acc_nxt;
            ctr_a <= ctr_a_sum[WIDTH-1:0];
            if (wrap_a) begin
                ctr_b <= ctr_b + WIDTH'(1);
            end
            if (last_chunk) begin
                z <= acc_nxt;
            end
        end
    end

endmodule
